nukv_rotation_matrix_loader: RTL
================================

Name: nukv_rotation_matrix_loader

Overview:
- Assembles a COL_COUNT x COL_COUNT rotation matrix from a word-serial configuration stream into a shadow buffer.
- Hands the matrix to the rotation stage through its matrix_data/matrix_valid inputs.
- Double-buffered: the active matrix changes only between values, never while a value is mid-transfer in the rotation datapath.

Parameters:
- COL_COUNT, 3, matrix dimension; N = COL_COUNT*COL_COUNT entries.
- COL_WIDTH, 64, bits per matrix entry / config word.
- RESET_IDENTITY, 0, 1: reset loads the identity matrix and asserts matrix_valid.
- FRAC_BITS, 16, fixed-point fraction bits; identity diagonal = 1<<FRAC_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_data  in  COL_WIDTH  matrix entry, row-major order.
- cfg_valid  in  1  cfg_data valid.
- cfg_last  in  1  marks the final entry of a matrix.
- cfg_ready  out  1  loader accepts a word.
- strm_active  in  1  high while a value is in flight in the rotation stage.
- strm_boundary  in  1  one-cycle pulse when the last beat of a value is accepted.
- matrix_data  out  N*COL_WIDTH  active matrix; entry k = r*COL_COUNT+c at bits [k*COL_WIDTH +: COL_WIDTH].
- matrix_valid  out  1  active matrix loaded.
- matrix_epoch  out  8  count of completed swaps, wraps 255->0.
- load_error  out  1  one-cycle pulse on a malformed load.

Behaviour:
- Reset, all synchronous:
  - state=FILL, count=0, shadow=0, matrix_epoch=0, load_error=0.
  - RESET_IDENTITY=0: matrix_data=0, matrix_valid=0.
  - RESET_IDENTITY=1: matrix_data=identity (diagonal 1<<FRAC_BITS, others 0), matrix_valid=1.
- Handshake: a beat is accepted when cfg_valid && cfg_ready. cfg_ready = !rst && state!=PENDING (combinational).
- State FILL, on an accepted beat:
  - Write cfg_data to shadow entry count.
  - count<N-1 and !cfg_last: count++.
  - count<N-1 and cfg_last: load_error pulses next cycle, count=0, stay FILL. Shadow contents are don't-care; the active matrix is untouched.
  - count==N-1 and cfg_last: count=0, state=PENDING.
  - count==N-1 and !cfg_last: load_error pulses, state=DRAIN.
- State DRAIN: accept and discard beats; on an accepted beat with cfg_last, go to FILL with count=0. The active matrix is untouched.
- State PENDING (cfg_ready=0):
  - swap_ok = !matrix_valid || !strm_active || strm_boundary.
  - In a swap_ok cycle: matrix_data<=shadow, matrix_valid<=1, matrix_epoch++, state<=FILL.
  - Otherwise hold in PENDING.
- Latency: last entry accepted in cycle t -> PENDING in t+1 -> with swap_ok in t+1, new matrix_data/matrix_valid visible at t+2. cfg_ready is back to 1 in t+2.
- Simultaneous strm_boundary and strm_active=1: the swap is allowed. The new matrix is first seen by the beat after the boundary.
- Once set, matrix_valid never deasserts except by reset.
- Reset mid-load, or while PENDING: the pending shadow is discarded and the reset values apply.
- matrix_data changes only in a swap cycle; it is stable in all other cycles.

Test Plan:
- RESET_IDENTITY=0, send 9 words 1..9 with last on the 9th, strm_active=0 -> matrix_valid=1 two cycles after the 9th beat, entry 0=1, entry 8=9, matrix_epoch=1.
- RESET_IDENTITY=1, FRAC_BITS=16, after reset -> matrix_valid=1, entries 0, 4, 8 = 0x10000, others 0, cfg_ready=1 in the first cycle after rst drops.
- Active matrix A loaded, strm_active=1, load matrix B -> cfg_ready=0 and matrix_data=A held for 20 cycles. Pulse strm_boundary -> matrix_data=B next cycle, matrix_epoch increments by 1.
- Send 5 words with last on the 5th -> load_error pulses once, matrix_data unchanged. A subsequent correct 9-word load succeeds.
- Send 12 words with last only on the 12th -> load_error pulses once at the 9th beat, words 10..12 drained, matrix unchanged. The next 9-word load succeeds.
- 256 back-to-back successful loads -> matrix_epoch wraps to 0. Assert rst while PENDING -> matrix_valid=0, epoch=0, no swap afterwards.

Source files
------------

// File: rtl/nukv_rotation_matrix_loader.sv
// nukv_rotation_matrix_loader
//
// Collects a COL_COUNT x COL_COUNT rotation matrix from a word-serial
// configuration stream into a shadow buffer. Once the shadow buffer holds a
// complete matrix, the loader copies it to the active matrix that drives the
// rotation stage. The copy happens only between values, so a value already in
// the rotation datapath always finishes with the matrix it started with.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cfg_data        matrix entry, row-major order
//   cfg_valid       cfg_data is valid
//   cfg_last        marks the final entry of a matrix
//   cfg_ready       loader can accept a word (combinational)
//   strm_active     a value is in flight in the rotation stage
//   strm_boundary   one-cycle pulse when the last beat of a value is accepted
//   matrix_data     active matrix, entry k=r*COL_COUNT+c at [k*COL_WIDTH +: COL_WIDTH]
//   matrix_valid    the active matrix holds a loaded matrix
//   matrix_epoch    number of completed swaps, wraps 255->0
//   load_error      one-cycle pulse after a malformed load
//
// Handshake: a cfg word moves on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_valid may be raised at any time. cfg_ready is
// low during reset and while a completed matrix waits to be swapped in.
module nukv_rotation_matrix_loader #(
  parameter int COL_COUNT      = 3,
  parameter int COL_WIDTH      = 64,
  parameter int RESET_IDENTITY = 0,
  parameter int FRAC_BITS      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COL_WIDTH-1:0]                   cfg_data,
  input  logic                                   cfg_valid,
  input  logic                                   cfg_last,
  output logic                                   cfg_ready,
  input  logic                                   strm_active,
  input  logic                                   strm_boundary,
  output logic [COL_COUNT*COL_COUNT*COL_WIDTH-1:0] matrix_data,
  output logic                                   matrix_valid,
  output logic [7:0]                             matrix_epoch,
  output logic                                   load_error
);

  localparam int N  = COL_COUNT * COL_COUNT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = N * COL_WIDTH;

  function automatic logic [MW-1:0] identity_matrix();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < COL_COUNT; i++) begin
      m[(i*COL_COUNT+i)*COL_WIDTH +: COL_WIDTH] = COL_WIDTH'(1) << FRAC_BITS;
    end
    return m;
  endfunction

  localparam logic [MW-1:0] RESET_MATRIX = (RESET_IDENTITY != 0) ? identity_matrix() : '0;
  localparam logic          RESET_VALID  = (RESET_IDENTITY != 0);
  localparam logic [CW-1:0] LAST_IDX     = CW'(N - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [MW-1:0] shadow;
  logic          err_next;
  logic          do_write;
  logic          do_swap;
  logic          beat;
  logic          swap_ok;

  assign cfg_ready = !rst && (state != PENDING);
  assign beat      = cfg_valid && cfg_ready;

  // A boundary pulse together with strm_active still permits the swap: the
  // value that just ended has had its last beat, so the next beat sees the
  // new matrix.
  assign swap_ok = !matrix_valid || !strm_active || strm_boundary;

  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = 1'b0;
    do_write   = 1'b0;
    do_swap    = 1'b0;
    case (state)
      FILL: begin
        if (beat) begin
          do_write = 1'b1;
          if (count != LAST_IDX) begin
            if (cfg_last) begin
              // Short matrix: flag it and restart from entry 0.
              err_next   = 1'b1;
              count_next = '0;
            end else begin
              count_next = count + 1'b1;
            end
          end else begin
            count_next = '0;
            if (cfg_last) begin
              state_next = PENDING;
            end else begin
              // Long matrix: flag it and drop words until its last marker.
              err_next   = 1'b1;
              state_next = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (beat && cfg_last) begin
          state_next = FILL;
          count_next = '0;
        end
      end
      PENDING: begin
        if (swap_ok) begin
          do_swap    = 1'b1;
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      count        <= '0;
      shadow       <= '0;
      matrix_epoch <= '0;
      load_error   <= 1'b0;
      matrix_data  <= RESET_MATRIX;
      matrix_valid <= RESET_VALID;
    end else begin
      state      <= state_next;
      count      <= count_next;
      load_error <= err_next;
      if (do_write) begin
        shadow[int'(count)*COL_WIDTH +: COL_WIDTH] <= cfg_data;
      end
      if (do_swap) begin
        matrix_data  <= shadow;
        matrix_valid <= 1'b1;
        matrix_epoch <= matrix_epoch + 8'd1;
      end
    end
  end

endmodule
